// File: rtl/instr_pkg.sv
// Shared types and constants for the instruction encoder/loader.
// Optional feature macro: ENC_CHECK_EN (field legality checks in instr_pack).
package instr_pkg;

    localparam int unsigned CLS_W  = 3;
    localparam int unsigned FLD_W  = 3;
    localparam int unsigned JPTR_W = 8;
    localparam int unsigned CODE_W = 9;

    typedef enum logic [CLS_W-1:0] {
        CLS_R    = 3'd0,
        CLS_BR   = 3'd1,
        CLS_ST   = 3'd2,
        CLS_LD   = 3'd3,
        CLS_MV   = 3'd4,
        CLS_HALT = 3'd5
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } enc_state_e;

    localparam logic [2:0]        OP_BR      = 3'b100;
    localparam logic [2:0]        OP_ST      = 3'b101;
    localparam logic [2:0]        OP_LD      = 3'b110;
    localparam logic [2:0]        OP_MV      = 3'b111;
    localparam logic [CODE_W-1:0] HALT_CODE  = 9'h0FF;
    localparam logic [FLD_W-1:0]  R_DST_BASE = 3'b100;

    // Symbolic instruction as presented on the input handshake.
    typedef struct packed {
        logic [CLS_W-1:0]  cls;
        logic [FLD_W-1:0]  aluop;
        logic [FLD_W-1:0]  ra;
        logic [FLD_W-1:0]  rb;
        logic [FLD_W-1:0]  rd;
        logic [FLD_W-1:0]  rs;
        logic [JPTR_W-1:0] jptr;
    } instr_fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic fields -> 9-bit machine code plus legality.
// Ports: fields_i (symbolic instruction), code_c_o (machine code),
//        legal_c_o (instruction may be written), halt_c_o (class is HALT).
// ENC_CHECK_EN: when defined, R-operand/destination, HALT-collision and
// branch-range checks clear legal_c_o; otherwise fields are truncated.
module instr_pack
    import instr_pkg::*;
(
    input  instr_fields_t     fields_i,
    output logic [CODE_W-1:0] code_c_o,
    output logic              legal_c_o,
    output logic              halt_c_o
);

    always_comb begin
        code_c_o  = '0;
        legal_c_o = 1'b1;
        halt_c_o  = 1'b0;
        case (fields_i.cls)
            CLS_R: begin
                code_c_o = {1'b0, fields_i.aluop, fields_i.ra[1:0],
                            fields_i.rb[1:0], fields_i.rd[0]};
`ifdef ENC_CHECK_EN
                // R destinations live in 4..5; an all-ones word would read back as HALT.
                if (fields_i.ra[2] || fields_i.rb[2] ||
                    (fields_i.rd[2:1] != R_DST_BASE[2:1]) ||
                    ({1'b0, fields_i.aluop, fields_i.ra[1:0], fields_i.rb[1:0],
                      fields_i.rd[0]} == HALT_CODE)) begin
                    legal_c_o = 1'b0;
                end
`endif
            end
            CLS_BR: begin
                code_c_o = {OP_BR, fields_i.jptr[5:0]};
`ifdef ENC_CHECK_EN
                if (fields_i.jptr[7:6] != 2'b00) begin
                    legal_c_o = 1'b0;
                end
`endif
            end
            CLS_ST:   code_c_o = {OP_ST, fields_i.rb, 3'b000};
            CLS_LD:   code_c_o = {OP_LD, fields_i.rd, 3'b000};
            CLS_MV:   code_c_o = {OP_MV, fields_i.rs, fields_i.rd};
            CLS_HALT: begin
                code_c_o = HALT_CODE;
                halt_c_o = 1'b1;
            end
            default:  legal_c_o = 1'b0;
        endcase
    end

`ifndef ENC_CHECK_EN
    // Bits dropped by silent truncation.
    logic unused_trunc;
    assign unused_trunc = ^{fields_i.ra[2], fields_i.jptr[7:6]};
`endif

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder/loader: packs symbolic instructions and
// writes them into instruction memory from address 0 upward.
// Ports: clk_i, rst_i (async, active-high); start_i begins a load;
//        in_valid_i/in_ready_o handshake with in_* instruction fields;
//        im_wr_en_o/im_addr_o/im_wdata_o memory write port;
//        busy_o, done_o, err_o, err_addr_o status.
// ENC_CHECK_EN: enables field legality checks inside instr_pack.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CLS_W-1:0]  in_class_i,
    input  logic [FLD_W-1:0]  in_aluop_i,
    input  logic [FLD_W-1:0]  in_ra_i,
    input  logic [FLD_W-1:0]  in_rb_i,
    input  logic [FLD_W-1:0]  in_rd_i,
    input  logic [FLD_W-1:0]  in_rs_i,
    input  logic [JPTR_W-1:0] in_jptr_i,
    output logic              im_wr_en_o,
    output logic [AW-1:0]     im_addr_o,
    output logic [CODE_W-1:0] im_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [AW-1:0]     err_addr_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    enc_state_e        state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [CODE_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [AW-1:0]     err_addr_q, err_addr_d;
    logic              run_q, run_d;

    instr_fields_t     fields_c;
    logic [CODE_W-1:0] code_c;
    logic              legal_c;
    logic              halt_c;

    always_comb begin
        fields_c       = '0;
        fields_c.cls   = in_class_i;
        fields_c.aluop = in_aluop_i;
        fields_c.ra    = in_ra_i;
        fields_c.rb    = in_rb_i;
        fields_c.rd    = in_rd_i;
        fields_c.rs    = in_rs_i;
        fields_c.jptr  = in_jptr_i;
    end

    instr_pack u_pack (
        .fields_i  (fields_c),
        .code_c_o  (code_c),
        .legal_c_o (legal_c),
        .halt_c_o  (halt_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        if (start_i) begin
            // start outranks any coincident handshake.
            state_d    = ST_RUN;
            addr_d     = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            err_addr_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (in_valid_i) begin
                        if (!legal_c) begin
                            state_d    = ST_ERR;
                            err_d      = 1'b1;
                            err_addr_d = addr_q;
                        end else begin
                            wr_en_d = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = code_c;
                            if (halt_c) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else if (addr_q == LAST_ADDR) begin
                                state_d    = ST_ERR;
                                err_d      = 1'b1;
                                err_addr_d = addr_q;
                            end
                            // Counter saturates at the last word.
                            if (addr_q != LAST_ADDR) begin
                                addr_d = AW'(addr_q + 1'b1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        run_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            run_q      <= run_d;
        end
    end

    assign in_ready_o = run_q;
    assign busy_o     = run_q;
    assign im_wr_en_o = wr_en_q;
    assign im_addr_o  = waddr_q;
    assign im_wdata_o = wdata_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

endmodule
